// File: rtl/dtree_engine.sv
// Decision-tree inference engine: loadable node table, one node visited per clock.
// Optional build macro DTREE_SIGNED_CMP_EN selects signed feature/threshold compare.
module dtree_engine #(
  parameter int WIDTH     = 8,
  parameter int X_NUM     = 4,
  parameter int ADDR_W    = 6,
  parameter int MAX_STEPS = 16,
  localparam int FIDX_W   = $clog2(X_NUM),
  localparam int NODE_W   = 1 + FIDX_W + WIDTH + 2*ADDR_W + WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [NODE_W-1:0]        cfg_data,
  input  logic                     start_i,
  input  logic [X_NUM*WIDTH-1:0]   x_i,
  output logic                     busy_o,
  output logic [WIDTH-1:0]         y_o,
  output logic                     y_valid_o,
  output logic                     error_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, WALK = 1'b1} state_t;

  localparam int NFEAT_PAD = 2**FIDX_W;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        pc_q, pc_d;
  logic [7:0]               steps_q, steps_d;
  logic [X_NUM*WIDTH-1:0]   feat_q, feat_d;
  logic [WIDTH-1:0]         y_q, y_d;
  logic                     y_valid_q, y_valid_d;
  logic                     error_q, error_d;

  logic [NODE_W-1:0]        table_q [2**ADDR_W];
  logic                     table_we;

  logic [NODE_W-1:0]        node;
  logic                     node_leaf;
  logic [FIDX_W-1:0]        node_fidx;
  logic [WIDTH-1:0]         node_cmp;
  logic [ADDR_W-1:0]        node_nxt_t;
  logic [ADDR_W-1:0]        node_nxt_f;
  logic [WIDTH-1:0]         node_val;

  logic [WIDTH-1:0]         feat_pad [NFEAT_PAD];
  logic [NFEAT_PAD-1:0]     fidx_ok_mask;
  logic [WIDTH-1:0]         feat_sel;
  logic                     fidx_ok;
  logic                     take_t;
  logic                     last_step;

  assign node       = table_q[pc_q];
  assign node_val   = node[WIDTH-1:0];
  assign node_nxt_f = node[WIDTH +: ADDR_W];
  assign node_nxt_t = node[WIDTH+ADDR_W +: ADDR_W];
  assign node_cmp   = node[WIDTH+2*ADDR_W +: WIDTH];
  assign node_fidx  = node[2*WIDTH+2*ADDR_W +: FIDX_W];
  assign node_leaf  = node[NODE_W-1];

  // Pad the feature bank to a power of two so any encodable fidx indexes safely;
  // the mask flags indices beyond X_NUM that must abort the walk.
  for (genvar gi = 0; gi < NFEAT_PAD; gi++) begin : g_feat
    if (gi < X_NUM) begin : g_real
      assign feat_pad[gi]     = feat_q[gi*WIDTH +: WIDTH];
      assign fidx_ok_mask[gi] = 1'b1;
    end else begin : g_pad
      assign feat_pad[gi]     = '0;
      assign fidx_ok_mask[gi] = 1'b0;
    end
  end

  assign feat_sel  = feat_pad[node_fidx];
  assign fidx_ok   = fidx_ok_mask[node_fidx];
  assign last_step = (steps_q == 8'(MAX_STEPS - 1));

`ifdef DTREE_SIGNED_CMP_EN
  assign take_t = ($signed(feat_sel) > $signed(node_cmp));
`else
  assign take_t = (feat_sel > node_cmp);
`endif

  // A write coinciding with start_i is dropped along with writes during WALK.
  assign table_we = cfg_we && (state_q == IDLE) && !start_i;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    steps_d   = steps_q;
    feat_d    = feat_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = WALK;
          feat_d  = x_i;
          pc_d    = '0;
          steps_d = '0;
        end
      end
      WALK: begin
        steps_d = steps_q + 8'd1;
        if (node_leaf) begin
          y_d       = node_val;
          y_valid_d = 1'b1;
          state_d   = IDLE;
        end else if (!fidx_ok || last_step) begin
          y_d       = '0;
          y_valid_d = 1'b1;
          error_d   = 1'b1;
          state_d   = IDLE;
        end else begin
          pc_d = take_t ? node_nxt_t : node_nxt_f;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      steps_q   <= '0;
      feat_q    <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      steps_q   <= steps_d;
      feat_q    <= feat_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      error_q   <= error_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) table_q[i] <= '0;
    end else if (table_we) begin
      table_q[cfg_addr] <= cfg_data;
    end
  end

  assign busy_o    = (state_q == WALK);
  assign y_o       = y_q;
  assign y_valid_o = y_valid_q;
  assign error_o   = error_q;

endmodule
